// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and defaults for the instruction-fetch front end
package fetch_ctrl_pkg;

    localparam int          ADDR_W_DEF      = 8;
    localparam int          INSTR_W_DEF     = 16;
    localparam logic [15:0] HALT_OPCODE_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry FIFO of {pc, instr} with flush, full and empty
import fetch_ctrl_pkg::*;

module fetch_queue #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               enq,
    input  logic [ADDR_W-1:0]  enq_pc,
    input  logic [INSTR_W-1:0] enq_instr,
    input  logic               deq,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic               full,
    output logic               empty
);

    // Entry 0 is always the head; entry 1 only holds data when two are queued.
    logic [ADDR_W-1:0]  e0_pc, e1_pc;
    logic [INSTR_W-1:0] e0_instr, e1_instr;
    logic [1:0]         count;

    // Storage update: flush wins, otherwise shift on dequeue and append on enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_pc    <= '0;
            e1_pc    <= '0;
            e0_instr <= '0;
            e1_instr <= '0;
            count    <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_pc    <= enq_pc;
                        e0_instr <= enq_instr;
                    end else begin
                        e1_pc    <= enq_pc;
                        e1_instr <= enq_instr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0_pc    <= e1_pc;
                    e0_instr <= e1_instr;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0_pc    <= enq_pc;
                        e0_instr <= enq_instr;
                    end else begin
                        e0_pc    <= e1_pc;
                        e0_instr <= e1_instr;
                        e1_pc    <= enq_pc;
                        e1_instr <= enq_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Head drives zero when nothing is queued so stale entries never leak out.
    always_comb begin
        empty      = (count == 2'd0);
        full       = (count == 2'd2);
        head_pc    = empty ? '0 : e0_pc;
        head_instr = empty ? '0 : e0_instr;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, IM addressing, decode queue, redirect, halt
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter int                 INSTR_W     = INSTR_W_DEF,
    parameter int                 PC_STEP     = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(HALT_OPCODE_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_en;
    logic               q_full, q_empty;
    logic               deq_fire, enq_fire;

    // A redirect discards both queue operations of its cycle.
    assign dec_valid = !q_empty;
    assign deq_fire  = dec_valid && dec_ready && !redirect_valid;
    assign enq_fire  = fetch_en && !redirect_valid && (!q_full || deq_fire);
    assign im_addr   = pc;

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .enq        (enq_fire),
        .enq_pc     (pc),
        .enq_instr  (im_instr),
        .deq        (deq_fire),
        .head_pc    (dec_pc),
        .head_instr (dec_instr),
        .full       (q_full),
        .empty      (q_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: redirect overrides everything; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_FETCH;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nxt = ST_FETCH;
                ST_FETCH: if (enq_fire && im_instr == HALT_OPCODE) state_nxt = ST_HALT;
                default:  ;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        fetch_en = (state == ST_FETCH);
        halted   = (state == ST_HALT);
    end

    // PC: redirect target forced even, otherwise advance on each enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc & ~ADDR_W'(1);
        else if (enq_fire)       pc <= pc + ADDR_W'(PC_STEP);
    end

    // Saturating count of enqueued instructions, kept across redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 fetch_count <= 16'h0000;
        else if (enq_fire && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'h0001;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the program counter logic and the combinational instruction memory (8-bit byte address, 16-bit instruction, instructions on even addresses). It owns the PC, drives the IM address every cycle, buffers fetched instructions in a 2-entry queue toward decode with a valid/ready handshake, and handles taken-branch redirects and the halt opcode. It replaces the implicit "address in, instruction out" usage with a cycle-accurate front end.

## Interface
- ADDR_W, 8, PC / IM address width
- INSTR_W, 16, instruction width
- PC_STEP, 2, PC increment per fetch (bytes)
- RESET_PC, 8'h00, PC value after reset
- HALT_OPCODE, 16'h0000, instruction that stops fetching
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching from current PC
- im_addr  out  ADDR_W  address to IM (combinational from PC register)
- im_instr  in  INSTR_W  IM read data, combinational from im_addr
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode accepts head
- dec_instr  out  INSTR_W  queue head instruction
- dec_pc  out  ADDR_W  PC of queue head
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  ADDR_W  redirect target
- halted  out  1  state is HALT
- fetch_count  out  16  instructions enqueued since reset, saturating at 16'hFFFF

## Operation
- States: IDLE (reset), FETCH, HALT. IDLE->FETCH on start; FETCH->HALT when enqueuing HALT_OPCODE; HALT->FETCH or IDLE->FETCH on redirect_valid. start ignored outside IDLE.
- Fetch (FETCH only): enqueue {pc, im_instr} when queue count < 2 or a dequeue occurs the same cycle; on enqueue pc <= pc + PC_STEP, modulo 2^ADDR_W (8'hFE -> 8'h00).
- Dequeue: dec_valid && dec_ready at rising edge; head removed.
- Queue: 2 entries, FIFO order; simultaneous enqueue and dequeue at count 2 allowed (count stays 2).
- Halt: halting instruction itself is enqueued and delivered; no further enqueue; queue drains normally; im_addr holds pc (address after halt).
- Redirect: highest priority in any state. At the edge: queue flushed (count 0, enqueue and dequeue of that cycle discarded, fetch_count not incremented), pc <= {redirect_pc[ADDR_W-1:1], 1'b0}, state FETCH.
- fetch_count increments once per enqueue; not cleared by redirect.

## Timing
- Reset values: pc = RESET_PC, state IDLE, queue empty, dec_valid 0, dec_instr 0, dec_pc 0, halted 0, fetch_count 0, im_addr = RESET_PC.
- im_addr = pc, zero-latency; IM read is same-cycle.
- start at edge k -> first enqueue at edge k+1 -> dec_valid high after k+1.
- Steady state with dec_ready held 1: one instruction per cycle, dec_pc increments by 2 each cycle.
- Redirect at edge r: dec_valid low during cycle after r; target instruction enqueued at r+1, visible after r+1 (1 bubble cycle).
- dec_instr/dec_pc stable while dec_valid && !dec_ready; dec_instr/dec_pc drive 0 when queue empty.
- rst_n low mid-operation: all state returns to reset values immediately (asynchronous), regardless of queue contents.

## Structure
- Shared package: state enum (IDLE, FETCH, HALT), ADDR_W/INSTR_W defaults, HALT_OPCODE constant.
- One sub-module: fetch_queue (2-entry FIFO of {pc, instr} with flush, count, full/empty); PC, FSM, counter in top.

## Test plan
- Reset then start, IM 0x00=F120, 0x02=F121, 0x04=93FF, dec_ready=1 -> dec_valid after 2 edges; dec_instr F120, F121, 93FF on consecutive cycles with dec_pc 00, 02, 04.
- dec_ready=0 for 5 cycles after start -> queue fills with 2 entries (00, 02), im_addr stops at 04, fetch_count=2; ready=1 -> 00, 02, 04 delivered in order, none skipped or duplicated.
- Redirect_valid with redirect_pc 8'h31 while queue full -> dec_valid low next cycle, next dec_pc 30, queued 00/02 never delivered.
- Halt: IM 0x38=0000 reached -> 0000 delivered with dec_pc 38, halted=1, im_addr holds 3A, fetch_count stops; redirect to 00 -> halted=0, fetching resumes at 00.
- PC wrap: redirect to FC with ready=1 -> dec_pc FC, FE, 00, 02.
- rst_n asserted asynchronously mid-stream with 2 entries queued -> dec_valid, halted, fetch_count, pc zero immediately without a clock edge; IDLE until start.
